// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer
// Buffers 24-bit stereo samples in a small FIFO and shifts them out as I2S on
// AUD_DACDAT. The codec clocks AUD_BCLK / AUD_DACLRCK are oversampled on
// CLOCK_50 and only their synchronized edges are used.
// Optional feature: define AUDIO_DAC_HOLD_EN to repeat the last popped stereo
// pair when a frame starts with the FIFO empty (default: output silence).
//
// state  | meaning
// UNSYNC | waiting for the first LRCK falling edge, output held at 0
// LEFT   | shifting the left-channel word
// RIGHT  | shifting the right-channel word
module audio_dac_serializer #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] writedata_left,
    input  logic [DATA_WIDTH-1:0] writedata_right,
    output logic                  write_ready,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_DACLRCK,
    output logic                  AUD_DACDAT,
    output logic                  underflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = $clog2(DATA_WIDTH + 2);
    localparam logic [BIT_W-1:0] BIT_DW   = BIT_W'(DATA_WIDTH);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {UNSYNC, LEFT, RIGHT} frame_state_t;

    frame_state_t state_q, state_d;

    logic bclk_s1, bclk_s2, bclk_d;
    logic lr_s1, lr_s2, lr_d;
    logic bclk_fall, lr_fall, lr_rise;

    logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [CNT_W-1:0]        count;
    logic                    fifo_empty, push, pop, starve;
    logic [2*DATA_WIDTH-1:0] fifo_head, fill_word, frame_word;

    logic                    load_frame, load_right;
    logic [DATA_WIDTH-1:0]   shreg, right_hold;
    logic [BIT_W-1:0]        bit_cnt;

    // Two-flop synchronizers plus one edge-detect stage per codec clock.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            bclk_s1 <= 1'b0;
            bclk_s2 <= 1'b0;
            bclk_d  <= 1'b0;
            lr_s1   <= 1'b0;
            lr_s2   <= 1'b0;
            lr_d    <= 1'b0;
        end else begin
            bclk_s1 <= AUD_BCLK;
            bclk_s2 <= bclk_s1;
            bclk_d  <= bclk_s2;
            lr_s1   <= AUD_DACLRCK;
            lr_s2   <= lr_s1;
            lr_d    <= lr_s2;
        end
    end

    assign bclk_fall = bclk_d & ~bclk_s2;
    assign lr_fall   = lr_d & ~lr_s2;
    assign lr_rise   = ~lr_d & lr_s2;

    assign write_ready = (count != CNT_FULL);
    assign fifo_empty  = (count == '0);
    assign push        = write && write_ready;
    assign fifo_head   = mem[rd_ptr];

    // FIFO storage, pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= {writedata_left, writedata_right};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef AUDIO_DAC_HOLD_EN
    logic [2*DATA_WIDTH-1:0] last_pair;

    // Remember the most recently popped pair so a starved frame can repeat it.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            last_pair <= '0;
        end else if (pop) begin
            last_pair <= fifo_head;
        end
    end

    assign fill_word = last_pair;
`else
    assign fill_word = '0;
`endif

    // Frame state register.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= UNSYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: every LRCK fall starts a new frame; LRCK rise only matters in LEFT.
    always_comb begin
        state_d    = state_q;
        load_frame = 1'b0;
        load_right = 1'b0;
        if (lr_fall) begin
            load_frame = 1'b1;
            state_d    = LEFT;
        end else if (lr_rise && (state_q == LEFT)) begin
            load_right = 1'b1;
            state_d    = RIGHT;
        end
    end

    // No empty bypass: a frame start with count==0 starves even if a push lands now.
    assign pop        = load_frame && !fifo_empty;
    assign starve     = load_frame && fifo_empty;
    assign frame_word = pop ? fifo_head : fill_word;

    // Shift path: a frame edge restarts the slot, and a coincident BCLK fall is its delay bit.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            shreg      <= '0;
            right_hold <= '0;
            bit_cnt    <= '0;
            AUD_DACDAT <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (starve) begin
                underflow <= 1'b1;
            end
            if (load_frame || load_right) begin
                if (load_frame) begin
                    shreg      <= frame_word[2*DATA_WIDTH-1:DATA_WIDTH];
                    right_hold <= frame_word[DATA_WIDTH-1:0];
                end else begin
                    shreg <= right_hold;
                end
                AUD_DACDAT <= 1'b0;
                bit_cnt    <= bclk_fall ? BIT_W'(1) : '0;
            end else if (bclk_fall && (state_q != UNSYNC)) begin
                if ((bit_cnt != '0) && (bit_cnt <= BIT_DW)) begin
                    AUD_DACDAT <= shreg[DATA_WIDTH-1];
                    shreg      <= {shreg[DATA_WIDTH-2:0], 1'b0};
                end else begin
                    AUD_DACDAT <= 1'b0;
                end
                if (bit_cnt != BIT_LAST) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench for audio_dac_serializer: a queue holds the pairs expected to
// be played; codec clocks run at 16 CLOCK_50 cycles per bit, 64 bits per frame.
module tb_audio_dac_serializer;

    localparam int DW    = 24;
    localparam int DEPTH = 8;

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic          write;
    logic [DW-1:0] writedata_left;
    logic [DW-1:0] writedata_right;
    logic          write_ready;
    logic          AUD_BCLK;
    logic          AUD_DACLRCK;
    logic          AUD_DACDAT;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    logic [2*DW-1:0] sb[$];
    logic [2*DW-1:0] last_pair;
    logic            exp_uf;

    always #10 CLOCK_50 = ~CLOCK_50;

    audio_dac_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .CLOCK_50        (CLOCK_50),
        .reset           (reset),
        .write           (write),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right),
        .write_ready     (write_ready),
        .AUD_BCLK        (AUD_BCLK),
        .AUD_DACLRCK     (AUD_DACLRCK),
        .AUD_DACDAT      (AUD_DACDAT),
        .underflow       (underflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // LRCK changing at the BCLK rise: slot bit 0 is the previous tail, bit 1 the delay slot.
    // LRCK changing with the BCLK fall: slot bit 0 is the delay slot.
    function automatic logic [31:0] slot_word(input bit aligned, input logic [DW-1:0] s);
        if (aligned) return {1'b0, s, 7'b0};
        return {2'b0, s, 6'b0};
    endfunction

    task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
        bit room;
        @(negedge CLOCK_50);
        write           = 1'b1;
        writedata_left  = l;
        writedata_right = r;
        room = (sb.size() != DEPTH);
        check("write_ready_at_push", write_ready, room);
        if (room) sb.push_back({l, r});
        @(negedge CLOCK_50);
        write = 1'b0;
    endtask

    // One BCLK period of 16 cycles; DACDAT sampled 6 cycles after the BCLK fall.
    task automatic codec_bit(input logic lr_new, input bit lr_at_fall, output logic sampled);
        @(negedge CLOCK_50);
        AUD_BCLK = 1'b0;
        if (lr_at_fall) AUD_DACLRCK = lr_new;
        repeat (6) @(negedge CLOCK_50);
        sampled = AUD_DACDAT;
        repeat (2) @(negedge CLOCK_50);
        AUD_BCLK = 1'b1;
        if (!lr_at_fall) AUD_DACLRCK = lr_new;
        repeat (7) @(negedge CLOCK_50);
    endtask

    task automatic play_frame(input bit aligned, output logic [31:0] l_bits, output logic [31:0] r_bits);
        logic b;
        l_bits = '0;
        r_bits = '0;
        for (int i = 0; i < 64; i++) begin
            codec_bit(i >= 32, aligned, b);
            if (i < 32) l_bits = {l_bits[30:0], b};
            else        r_bits = {r_bits[30:0], b};
        end
    endtask

    task automatic check_frame(input bit aligned, input string tag);
        logic [2*DW-1:0] exp_pair;
        logic [31:0]     lb, rb;
        if (sb.size() != 0) begin
            exp_pair  = sb.pop_front();
            last_pair = exp_pair;
        end else begin
            exp_uf = 1'b1;
`ifdef AUDIO_DAC_HOLD_EN
            exp_pair = last_pair;
`else
            exp_pair = '0;
`endif
        end
        play_frame(aligned, lb, rb);
        check({tag, "_left"}, lb, slot_word(aligned, exp_pair[2*DW-1:DW]));
        check({tag, "_right"}, rb, slot_word(aligned, exp_pair[DW-1:0]));
        check({tag, "_underflow"}, underflow, exp_uf);
    endtask

    initial begin
        logic            b;
        logic [31:0]     zbits;
        logic [53:0]     tail;
        logic [31:0]     w;
        logic [2*DW-1:0] p1;
        logic [DW-1:0]   lv;

        reset           = 1'b1;
        write           = 1'b0;
        writedata_left  = '0;
        writedata_right = '0;
        AUD_BCLK        = 1'b1;
        AUD_DACLRCK     = 1'b1;
        last_pair       = '0;
        exp_uf          = 1'b0;

        repeat (3) @(negedge CLOCK_50);
        check("reset_dacdat", AUD_DACDAT, 1'b0);
        check("reset_write_ready", write_ready, 1'b1);
        check("reset_underflow", underflow, 1'b0);
        reset = 1'b0;

        // Half a frame with LRCK high: still UNSYNC, output silent.
        zbits = '0;
        for (int i = 0; i < 32; i++) begin
            codec_bit(1'b1, 1'b0, b);
            zbits = {zbits[30:0], b};
        end
        check("unsync_silent", zbits, 32'h0);
        check("unsync_underflow", underflow, exp_uf);

        push_pair(24'hA5A5A5, 24'h3C3C3C);
        check_frame(1'b0, "a5_3c");

        // Fill the FIFO with LRCK idle; the ninth write must be refused.
        for (int k = 0; k < 8; k++) begin
            lv = 24'(32'h123457 * (k + 1));
            push_pair(lv, ~lv);
        end
        check("full_ready_low", write_ready, sb.size() != DEPTH);
        push_pair(24'hDEAD00, 24'h00BEEF);
        for (int k = 0; k < 8; k++) begin
            check_frame(1'b0, "drain");
            if (k == 0) check("ready_after_pop", write_ready, sb.size() != DEPTH);
        end
        check_frame(1'b0, "starve_after_drain");

        push_pair(24'(40000), 24'(-40000));
        check_frame(1'b0, "pm40000");
        check_frame(1'b0, "starve_pm40000");

        push_pair(24'h800001, 24'h7FFFFE);
        check_frame(1'b1, "aligned");

        // Reset in the middle of the left word.
        push_pair(24'hFFFFFF, 24'h000001);
        push_pair(24'h111111, 24'h222222);
        p1 = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            codec_bit(1'b0, 1'b0, b);
        end
        w = slot_word(1'b0, p1[2*DW-1:DW]);
        check("pre_reset_bit", b, w[22]);
        @(negedge CLOCK_50);
        reset = 1'b1;
        sb.delete();
        last_pair = '0;
        exp_uf    = 1'b0;
        #1;
        check("midreset_dacdat", AUD_DACDAT, 1'b0);
        check("midreset_write_ready", write_ready, sb.size() != DEPTH);
        check("midreset_underflow", underflow, exp_uf);
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        tail = '0;
        for (int i = 10; i < 64; i++) begin
            codec_bit(i >= 32, 1'b0, b);
            tail = {tail[52:0], b};
        end
        check("post_reset_silent", tail, 54'h0);
        check("post_reset_underflow", underflow, exp_uf);

        push_pair(24'h5A0F3C, 24'hC3F0A5);
        check_frame(1'b0, "post_reset_play");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_dac_serializer.md
# audio_dac_serializer

Write-side sink for the 24-bit stereo sample stream produced by the game's tone generators. It accepts samples through the same `write`/`write_ready` handshake that sound sources already drive, buffers them in a small FIFO, and shifts them out serially on `AUD_DACDAT` in I2S format, aligned to the codec's `AUD_BCLK` and `AUD_DACLRCK`. All logic runs on `CLOCK_50`. The codec bit clocks are oversampled; they are not used as clocks.

## Interface
- `DATA_WIDTH`, 24: bits per channel sample.
- `FIFO_DEPTH`, 8: stereo pairs buffered. Must be a power of two, ≥2.
- `CLOCK_50`  in  1  system clock; every flop samples on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `write`  in  1  push request. Qualified by `write_ready`.
- `writedata_left`  in  DATA_WIDTH  left sample (two's complement).
- `writedata_right`  in  DATA_WIDTH  right sample (two's complement).
- `write_ready`  out  1  FIFO not full.
- `AUD_BCLK`  in  1  codec bit clock (asynchronous).
- `AUD_DACLRCK`  in  1  codec frame clock (asynchronous). Low = left channel.
- `AUD_DACDAT`  out  1  serial data to the codec.
- `underflow`  out  1  sticky; set when a frame starts with the FIFO empty.

## Operation
- Synchronizers:
  - `AUD_BCLK` and `AUD_DACLRCK` each pass through a 2-flop synchronizer, then an edge-detect register.
  - The design uses `bclk_fall`, `lr_fall` and `lr_rise` pulses, each one cycle wide.
- FIFO:
  - A push happens when `write && write_ready`. It stores {left, right} as one entry.
  - `write_ready = (count != FIFO_DEPTH)` and is derived from the registered count.
  - Push and pop in the same cycle: count is unchanged and both pointers advance.
  - Full: `write_ready` is low, so a simultaneous pop does not free the slot until the next cycle.
  - There is no empty bypass. A pop request while `count == 0` is an underflow, even if a push happens in that cycle.
- Frame FSM, states UNSYNC, LEFT, RIGHT:
  - UNSYNC: entered on reset. `AUD_DACDAT` is held at 0. Goes to LEFT on the first `lr_fall`.
  - On `lr_fall`, from any state:
    - If the FIFO is not empty: pop and load the left/right shift registers.
    - If it is empty: load the underflow word and set `underflow`.
    - Clear the bit counter and enter LEFT.
  - On `lr_rise` in LEFT: move the held right word into the shift register, clear the bit counter, enter RIGHT.
  - `lr_rise` while in RIGHT or UNSYNC is ignored.
- Bit shifting, once per `bclk_fall` in LEFT or RIGHT:
  - Bit counter 0 is the I2S delay slot and drives 0.
  - Counters 1..DATA_WIDTH drive sample bit [DATA_WIDTH−counter], so the MSB goes first.
  - Counters above DATA_WIDTH drive 0.
  - The counter saturates at DATA_WIDTH+1.
- Simultaneous `lr_fall`/`lr_rise` and `bclk_fall` in the same cycle:
  - The frame edge is processed first.
  - That `bclk_fall` counts as the delay slot (counter becomes 1 and DACDAT = 0).
- `underflow` clears only on `reset`.

## Timing
- Reset values:
  - `AUD_DACDAT` = 0, `write_ready` = 1, `underflow` = 0.
  - FSM = UNSYNC, FIFO empty, shift registers 0.
- A change on `AUD_DACDAT` occurs 3 `CLOCK_50` cycles after the `AUD_BCLK` falling edge at the pin: 2 synchronizer cycles plus 1 edge/output register.
- Requirement: the `AUD_BCLK` period must be ≥8 `CLOCK_50` cycles. The nominal 3.072 MHz gives about 16 cycles.
- Push to visible count: 1 cycle. `write_ready` falls the cycle after the push that fills the FIFO.
- Reset mid-frame: `AUD_DACDAT` goes to 0 immediately (async). Output stays 0 until the next `lr_fall` after release; no partial frame is emitted.

## Configuration
- `AUDIO_DAC_HOLD_EN` defined: the underflow word is the last popped stereo pair, so the held sample repeats.
- Not defined: the underflow word is all zeros (silence).
- `underflow` is set in both cases.

## Test plan
- Reset, LRCK/BCLK running at 48 kHz×64: `AUD_DACDAT` = 0 during the first partial frame. FSM leaves UNSYNC only at the first LRCK falling edge.
- Push L=24'hA5A5A5, R=24'h3C3C3C, then one frame:
  - Left slot: a 0 delay bit, then A5A5A5 MSB-first, then zeros.
  - Right slot: 3C3C3C in the same layout.
  - `underflow` stays 0.
- Push 8 pairs with no LRCK activity: `write_ready` goes low the cycle after the 8th push, and a 9th `write` is dropped. After the next `lr_fall` pop, `write_ready` = 1.
- Empty FIFO at `lr_fall`:
  - Macro off: a zero frame is output and `underflow` = 1.
  - `AUDIO_DAC_HOLD_EN` on: the previous pair (e.g. ±40000) repeats bit-exactly.
- Align a BCLK falling edge and an LRCK falling edge to the same `CLOCK_50` cycle: that edge is the delay slot, and the MSB appears on the following BCLK fall.
- Assert `reset` mid-left-word: `AUD_DACDAT` = 0 at once and the FIFO empties. After release, output stays silent until the next `lr_fall` and then plays newly pushed data.
